// File: rtl/mdio_pkg.sv
// Shared MDIO definitions for the station-manager controller and the PHY-side receiver.
// Latency: n/a (constants, types and a decode helper only).
// Backpressure: n/a.
package mdio_pkg;

  // FSM state encodings
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ENVIAR  = 2'd1;
  localparam logic [1:0] RECIBIR = 2'd2;

  // Frame field codes
  localparam logic [1:0] ST_START = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  // Field bit positions inside the 32-bit frame
  localparam int OP_HI    = 29;
  localparam int OP_LO    = 28;
  localparam int REGAD_HI = 22;
  localparam int REGAD_LO = 18;

  localparam int FRAME_BITS = 32;
  localparam int HALF_BITS  = 16;

  typedef struct packed {
    logic [1:0]  st;
    logic [1:0]  op;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic [1:0]  ta;
    logic [15:0] data;
  } mdio_frame_t;

  // Only OP=10 is a read; every other code is sent as a full 32-bit write.
  function automatic logic is_read(input logic [31:0] frame);
    return frame[OP_HI:OP_LO] == OP_READ;
  endfunction

endpackage

// File: rtl/generador_mdc.sv
// MDC generator: clk/2 divider with enable, mdc held at 0 while disabled.
// Latency: first rising mdc one clk after en rises; rise_ev/fall_ev flag the edge about to toggle mdc.
// Backpressure: none; en is the only control.
//
// Ports:
//   clk     in  system clock
//   reset   in  synchronous active-low reset
//   en      in  1 = run the divider
//   mdc     out management clock
//   rise_ev out 1 = the next clk edge drives mdc 0->1
//   fall_ev out 1 = the next clk edge drives mdc 1->0
module generador_mdc (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic mdc,
  output logic rise_ev,
  output logic fall_ev
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      mdc <= 1'b0;
    end else if (!en) begin
      mdc <= 1'b0;
    end else begin
      mdc <= ~mdc;
    end
  end

  // Strobes look ahead one edge so the controller can update data on the
  // same edge that drops mdc, keeping mdio_out stable across the rise.
  assign rise_ev = en & ~mdc;
  assign fall_ev = en & mdc;

endmodule

// File: rtl/controlador_mdio.sv
// MDIO station manager: shifts a 32-bit frame out MSB first and, for reads, captures 16 bits LSB first.
// Latency: 64 clk from accepted mdio_start to the mdio_done pulse, reads and writes alike.
// Backpressure: mdio_start is ignored while busy; a new start is taken the cycle after busy falls.
//
// Ports:
//   clk        in  system clock (mdc = clk/2 during a frame)
//   reset      in  synchronous active-low reset
//   mdio_start in  one-cycle request, accepted only when idle
//   t_data     in  frame {ST, OP, PHYAD, REGAD, TA, DATA}
//   mdio_in    in  serial data from the PHY
//   mdc        out management clock
//   mdio_out   out serial data to the PHY
//   mdio_oe    out 1 = controller drives MDIO
//   rd_data    out captured read data
//   data_rdy   out one-cycle pulse at read completion
//   mdio_done  out one-cycle pulse at end of every frame
//   busy       out high from accepted start through the mdio_done cycle
module controlador_mdio
  import mdio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mdio_start,
  input  logic [31:0] t_data,
  input  logic        mdio_in,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic [15:0] rd_data,
  output logic        data_rdy,
  output logic        mdio_done,
  output logic        busy
);

  logic [1:0]  state;
  logic [31:0] shreg;
  logic [4:0]  bit_cnt;
  logic        rd_op;
  logic        mdc_en;
  logic        fall_ev;
  logic        rise_unused;

  // The divider only runs while a frame is in flight; it is idle (mdc=0)
  // on the acceptance edge, so edge 1 is the first mdc rise.
  assign mdc_en = (state != IDLE);

  generador_mdc u_gen (
    .clk     (clk),
    .reset   (reset),
    .en      (mdc_en),
    .mdc     (mdc),
    .rise_ev (rise_unused),
    .fall_ev (fall_ev)
  );

  // busy stays high through the done cycle so a start coinciding with
  // mdio_done is ignored.
  assign busy = (state != IDLE) | mdio_done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      rd_op     <= 1'b0;
      mdio_out  <= 1'b0;
      mdio_oe   <= 1'b0;
      rd_data   <= '0;
      data_rdy  <= 1'b0;
      mdio_done <= 1'b0;
    end else begin
      mdio_done <= 1'b0;
      data_rdy  <= 1'b0;

      case (state)
        IDLE: begin
          if (mdio_start && !busy) begin
            shreg    <= t_data;
            rd_op    <= is_read(t_data);
            bit_cnt  <= '0;
            mdio_oe  <= 1'b1;
            mdio_out <= t_data[FRAME_BITS-1];
            state    <= ENVIAR;
          end
        end

        ENVIAR: begin
          // bit_cnt holds the index of the bit that was just sampled on the
          // preceding mdc rise.
          if (fall_ev) begin
            if (bit_cnt == 5'(FRAME_BITS - 1)) begin
              state     <= IDLE;
              mdio_oe   <= 1'b0;
              mdio_out  <= 1'b0;
              mdio_done <= 1'b1;
              bit_cnt   <= '0;
            end else if (rd_op && (bit_cnt == 5'(HALF_BITS - 1))) begin
              // Turnaround: release the line, keep counting through the
              // data phase so the counter ends at 31 for both frame types.
              state    <= RECIBIR;
              mdio_oe  <= 1'b0;
              mdio_out <= 1'b0;
              bit_cnt  <= bit_cnt + 5'd1;
            end else begin
              shreg    <= {shreg[FRAME_BITS-2:0], 1'b0};
              mdio_out <= shreg[FRAME_BITS-2];
              bit_cnt  <= bit_cnt + 5'd1;
            end
          end
        end

        RECIBIR: begin
          if (fall_ev) begin
            // bit_cnt runs 16..31 here; its low nibble is the data bit index.
            rd_data[bit_cnt[3:0]] <= mdio_in;
            if (bit_cnt == 5'(FRAME_BITS - 1)) begin
              state     <= IDLE;
              mdio_done <= 1'b1;
              data_rdy  <= 1'b1;
              bit_cnt   <= '0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          mdio_oe <= 1'b0;
          mdio_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_mdio.sv
// Self-checking bench for controlador_mdio with a behavioural PHY and frame monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_controlador_mdio;
  import mdio_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdio_start;
  logic [31:0] t_data;
  logic        mdio_in;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic [15:0] rd_data;
  logic        data_rdy;
  logic        mdio_done;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [15:0] model_rd;

  always #5 clk = ~clk;

  controlador_mdio dut (
    .clk        (clk),
    .reset      (reset),
    .mdio_start (mdio_start),
    .t_data     (t_data),
    .mdio_in    (mdio_in),
    .mdc        (mdc),
    .mdio_out   (mdio_out),
    .mdio_oe    (mdio_oe),
    .rd_data    (rd_data),
    .data_rdy   (data_rdy),
    .mdio_done  (mdio_done),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] word;     // bits seen on mdio_out at mdc rises, first bit in MSB
    int          rises;
    int          done_edge;
    int          rdy_edge;
    int          oe_fall;
    int          done_cnt;
    int          rdy_cnt;
    int          viol;
    logic [15:0] rd;
  } obs_t;

  // Called at a negedge. Starts a frame, plays the PHY (returns phy LSB first
  // after the 16th mdc rise) and records what is seen for 66 clk edges.
  task automatic run_frame(input logic [31:0] td, input logic [15:0] phy,
                           input bit rebusy, output obs_t o);
    logic prev;
    prev        = 1'b0;
    o.word      = '0;
    o.rises     = 0;
    o.done_edge = -1;
    o.rdy_edge  = -1;
    o.oe_fall   = -1;
    o.done_cnt  = 0;
    o.rdy_cnt   = 0;
    o.viol      = 0;
    t_data      = td;
    mdio_start  = 1'b1;
    mdio_in     = 1'b0;
    @(posedge clk);  // edge 0
    for (int k = 0; k <= 65; k++) begin
      @(negedge clk);
      if (k == 0) begin
        mdio_start = 1'b0;
        if (!(mdio_oe === 1'b1 && mdc === 1'b0 && mdio_out === td[31] && busy === 1'b1))
          o.viol++;
      end
      if (mdc === 1'b1 && prev === 1'b0) begin
        o.rises++;
        if (o.rises <= 32) o.word = {o.word[30:0], mdio_out};
        if (o.rises >= 17 && o.rises <= 32) mdio_in = phy[o.rises-17];
      end
      prev = mdc;
      if (mdio_done === 1'b1) begin
        o.done_cnt++;
        if (o.done_edge < 0) o.done_edge = k;
      end
      if (data_rdy === 1'b1) begin
        o.rdy_cnt++;
        if (o.rdy_edge < 0) o.rdy_edge = k;
      end
      if (mdio_oe !== 1'b1 && o.oe_fall < 0) o.oe_fall = k;
      if (mdio_oe !== 1'b1 && mdio_out !== 1'b0) o.viol++;
      if (busy !== (k <= 64)) o.viol++;
      if (rebusy && k == 9) begin
        mdio_start = 1'b1;
        t_data     = ~td;
      end
      if (rebusy && k == 10) mdio_start = 1'b0;
    end
    o.rd = rd_data;
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    mdio_start = 1'b1;
    t_data     = $urandom;
    mdio_in    = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({mdc, mdio_out, mdio_oe, data_rdy, mdio_done, busy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=000000",
               {mdc, mdio_out, mdio_oe, data_rdy, mdio_done, busy});
    end
    total++;
    if (rd_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_rd_data got=%h want=0000", rd_data);
    end
    mdio_start = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_wins_over_start busy=%b want=0", busy);
    end
    model_rd = 16'h0000;
  endtask

  task automatic check_frame(input string nm, input obs_t o, input logic [31:0] td,
                             input logic [15:0] phy);
    logic        rd;
    logic [31:0] exp_word;
    rd       = (td[OP_HI:OP_LO] == OP_READ);
    exp_word = rd ? {td[31:16], 16'h0000} : td;
    if (rd) model_rd = phy;
    total++;
    if (o.word !== exp_word) begin
      bad++;
      $display("FAIL %s_bits got=%h want=%h", nm, o.word, exp_word);
    end
    total++;
    if (o.rises != 32) begin
      bad++;
      $display("FAIL %s_rises got=%0d want=32", nm, o.rises);
    end
    total++;
    if (o.done_edge != 64 || o.done_cnt != 1) begin
      bad++;
      $display("FAIL %s_done edge=%0d count=%0d want edge=64 count=1", nm, o.done_edge, o.done_cnt);
    end
    total++;
    if (o.rdy_edge != (rd ? 64 : -1) || o.rdy_cnt != (rd ? 1 : 0)) begin
      bad++;
      $display("FAIL %s_rdy edge=%0d count=%0d want edge=%0d", nm, o.rdy_edge, o.rdy_cnt, rd ? 64 : -1);
    end
    total++;
    if (o.oe_fall != (rd ? 32 : 64)) begin
      bad++;
      $display("FAIL %s_oe_fall got=%0d want=%0d", nm, o.oe_fall, rd ? 32 : 64);
    end
    total++;
    if (o.rd !== model_rd) begin
      bad++;
      $display("FAIL %s_rd_data got=%h want=%h", nm, o.rd, model_rd);
    end
    total++;
    if (o.viol != 0) begin
      bad++;
      $display("FAIL %s_line_rules violations=%0d want=0", nm, o.viol);
    end
  endtask

  task automatic test_write();
    obs_t o;
    logic [15:0] phy;
    phy = 16'($urandom);
    run_frame(32'h5A3C_BEEF, phy, 1'b0, o);
    check_frame("write", o, 32'h5A3C_BEEF, phy);
  endtask

  task automatic test_read();
    obs_t o;
    run_frame(32'h6A3C_0000, 16'hA5C3, 1'b0, o);
    check_frame("read", o, 32'h6A3C_0000, 16'hA5C3);
  endtask

  task automatic test_start_while_busy();
    obs_t o;
    logic [31:0] td;
    td = {ST_START, OP_WRITE, 28'($urandom)};
    run_frame(td, 16'h0, 1'b1, o);
    check_frame("busy_restart", o, td, 16'h0);
  endtask

  task automatic test_reset_mid_frame();
    obs_t o;
    int seen;
    seen       = 0;
    t_data     = 32'h6A3C_0000;
    mdio_start = 1'b1;
    mdio_in    = 1'b1;
    @(posedge clk);  // edge 0
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) mdio_start = 1'b0;
      if (k == 39) reset = 1'b0;
    end
    @(negedge clk);  // after edge 40
    total++;
    if ({mdc, mdio_oe, mdio_out, mdio_done, data_rdy, busy} !== 6'b0) begin
      bad++;
      $display("FAIL midreset_outputs got=%b want=000000",
               {mdc, mdio_oe, mdio_out, mdio_done, data_rdy, busy});
    end
    total++;
    if (rd_data !== 16'h0000) begin
      bad++;
      $display("FAIL midreset_rd_data got=%h want=0000", rd_data);
    end
    repeat (2) begin
      @(negedge clk);
      if (mdio_done === 1'b1 || data_rdy === 1'b1) seen++;
    end
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mdio_done === 1'b1 || data_rdy === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midreset_no_pulses got=%0d events want=0", seen);
    end
    model_rd = 16'h0000;
    run_frame(32'h6A3C_0000, 16'h3C5A, 1'b0, o);
    check_frame("after_reset", o, 32'h6A3C_0000, 16'h3C5A);
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    logic [31:0] tw, tr;
    logic [15:0] phy;
    tw  = {ST_START, OP_WRITE, 28'($urandom)};
    tr  = {ST_START, OP_READ, 28'($urandom)};
    phy = 16'($urandom);
    run_frame(tw, 16'h0, 1'b0, o1);
    run_frame(tr, phy, 1'b0, o2);
    check_frame("b2b_write", o1, tw, 16'h0);
    check_frame("b2b_read", o2, tr, phy);
    total++;
    if (o1.rises + o2.rises != 64) begin
      bad++;
      $display("FAIL b2b_total_rises got=%0d want=64", o1.rises + o2.rises);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [31:0] td;
    logic [15:0] phy;
    for (int n = 0; n < 8; n++) begin
      td  = $urandom;
      phy = 16'($urandom);
      if (n < 4) td[OP_HI:OP_LO] = 2'(n);  // cover every OP code
      run_frame(td, phy, 1'b0, o);
      check_frame("random", o, td, phy);
    end
  endtask

  // Stand-in for the PHY-side receiver: decodes the frame seen on the wire.
  task automatic test_loopback();
    obs_t o;
    logic [31:0] td;
    mdio_frame_t f;
    logic [4:0] reg_addr;
    logic [15:0] mdio_data_write;
    f.st    = ST_START;
    f.op    = OP_WRITE;
    f.phyad = 5'd1;
    f.regad = 5'd5;
    f.ta    = 2'b10;
    f.data  = 16'h1234;
    td      = f;
    run_frame(td, 16'h0, 1'b0, o);
    reg_addr        = o.word[REGAD_HI:REGAD_LO];
    mdio_data_write = o.word[15:0];
    total++;
    if (o.word[31:28] !== {ST_START, OP_WRITE} || reg_addr !== 5'd5) begin
      bad++;
      $display("FAIL loopback_reg_addr got=%0d st_op=%b want=5 st_op=0101", reg_addr, o.word[31:28]);
    end
    total++;
    if (mdio_data_write !== 16'h1234) begin
      bad++;
      $display("FAIL loopback_data got=%h want=1234", mdio_data_write);
    end
  endtask

  initial begin
    reset      = 1'b0;
    mdio_start = 1'b0;
    t_data     = '0;
    mdio_in    = 1'b0;
    model_rd   = '0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controlador_mdio.md
# controlador_mdio

MDIO management-side controller (station manager) that serializes a 32-bit management frame onto MDIO and, for reads, releases the line and captures the 16-bit PHY response. It generates MDC from the system clock and is the counterpart of the PHY-side MDIO receiver. It sits between the register-access requester and the MDIO pins.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; MDC = clk/2 while a frame is active.
- reset  in  1  synchronous, active-low (0 = reset).
- mdio_start  in  1  one-cycle request; sampled only in IDLE.
- t_data  in  32  frame: [31:30] ST, [29:28] OP, [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] write data. Latched on accepted start.
- mdio_in  in  1  serial data from the PHY during the read data phase.
- mdc  out  1  management clock to the PHY.
- mdio_out  out  1  serial data to the PHY.
- mdio_oe  out  1  1 = controller drives MDIO.
- rd_data  out  16  captured read data; holds until the next read completes.
- data_rdy  out  1  one-cycle pulse when rd_data is updated.
- mdio_done  out  1  one-cycle pulse at the end of any frame.
- busy  out  1  high from accepted start until the mdio_done cycle (inclusive).

## Operation
- States: IDLE, ENVIAR (drive bits), RECIBIR (read data phase).
- IDLE + mdio_start=1: latch t_data, bit counter = 0, go to ENVIAR.
- Frame bits are sent MSB first (t_data[31] first). Each bit spans 2 clk cycles: low phase of mdc, then high phase.
- mdio_out changes only on edges that drive mdc 1->0, or on the start edge. The PHY samples on the rising edge of mdc.
- Read is decoded as t_data[29:28] == 2'b10. Every other OP code is treated as a write (all 32 bits driven).
- Write: ENVIAR for 32 bits with mdio_oe=1, then return to IDLE.
- Read: ENVIAR for bits 31..16 (ST, OP, PHYAD, REGAD, TA), then mdio_oe=0 and go to RECIBIR for 16 bit periods.
- In RECIBIR, mdio_in is sampled on each edge that drives mdc 1->0. The data is LSB first: the j-th data bit goes to rd_data[j], j = 0..15.
- mdio_start is ignored while busy=1.
- mdio_out is 0 whenever mdio_oe=0.

## Timing
Edge 0 is the clk edge that accepts mdio_start.
- Edge 0: mdio_oe=1, mdio_out=t_data[31], mdc=0, busy=1.
- Edge 2i+1: mdc=1; bit i is stable on mdio_out.
- Edge 2i+2 (i<31): mdc=0, mdio_out=t_data[30-i].
- Write, edge 64: mdc=0, mdio_oe=0, mdio_out=0, mdio_done=1, state IDLE. busy falls at edge 65.
- Read, edge 32: mdio_oe=0, state RECIBIR.
- Read, edges 34+2j (j=0..15): rd_data[j] <= mdio_in.
- Read, edge 64: the last sample is taken, data_rdy=1, mdio_done=1, state IDLE.
- Latency from start to mdio_done is 64 clk for both reads and writes. mdc toggles 64 times per frame, and exactly 32 rising edges occur per frame.
- Back-to-back: a start asserted in the cycle after mdio_done (busy already 0) is accepted. There is no idle gap requirement.
- Reset values: mdc=0, mdio_out=0, mdio_oe=0, rd_data=16'h0000, data_rdy=0, mdio_done=0, busy=0, state IDLE, counter 0.
- Reset mid-frame: all outputs take their reset values on that edge. The frame is aborted with no mdio_done or data_rdy, and rd_data is cleared.
- reset=0 and mdio_start=1 on the same edge: reset wins.

## Structure
- Shared package mdio_pkg holds:
  - state encodings (IDLE, ENVIAR, RECIBIR);
  - ST_START=2'b01, OP_WRITE=2'b01, OP_READ=2'b10;
  - field bit positions (OP_HI=29, OP_LO=28, REGAD_HI=22, REGAD_LO=18);
  - FRAME_BITS=32 and HALF_BITS=16.
- The PHY-side receiver uses the same package.
- One sub-module: generador_mdc, a clk/2 divider with enable. It outputs mdc plus one-cycle rise_ev/fall_ev strobes, is held at 0 when disabled, and uses the same synchronous active-low reset.
- The controller FSM, shift register and bit counter stay in controlador_mdio.

## Test plan
- Write: t_data=32'h5A3C_BEEF (OP=01) -> the bits 0101_1010_0011_1100_1011_1110_1110_1111 are seen on mdio_out at the 32 mdc rising edges. mdio_oe=1 throughout. mdio_done pulses at edge 64 and data_rdy stays 0.
- Read: t_data=32'h6A3C_0000 (OP=10), with a PHY model returning 16'hA5C3 LSB first -> mdio_oe falls at edge 32, rd_data=16'hA5C3, and data_rdy and mdio_done pulse together at edge 64.
- Start while busy: mdio_start re-pulsed at edge 10 with different t_data -> ignored; the original frame completes unchanged.
- Reset mid-frame: reset=0 at edge 40 of a read -> mdc, mdio_oe, mdio_out and rd_data are 0 on that edge, with no done or rdy pulse. The next start after release runs a full frame.
- Back-to-back: a write immediately followed by a read, start asserted the cycle after mdio_done -> both frames are correct and there are exactly 64 mdc rising edges in total.
- Loopback with the PHY-side MDIO receiver: write 16'h1234 to REGAD 5 -> the receiver reports reg_addr=5 and mdio_data_write=16'h1234.
